// File: rtl/zeroriscy_irq_arbiter.sv
// Interrupt arbiter feeding the zero-riscy irq_i/irq_id_i handshake: pending/mask registers plus IDLE/REQ/DONE request FSM.
// Optional build macro IRQ_EDGE_DETECT_EN selects rising-edge source capture instead of level capture.
module zeroriscy_irq_arbiter #(
    parameter int NUM_IRQ = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_src_i,
    input  logic               mask_we_i,
    input  logic [NUM_IRQ-1:0] mask_wdata_i,
    input  logic [NUM_IRQ-1:0] pend_set_i,
    input  logic [NUM_IRQ-1:0] pend_clr_i,
    output logic               irq_o,
    output logic [4:0]         irq_id_o,
    input  logic               irq_ack_i,
    input  logic [4:0]         irq_ack_id_i,
    output logic [NUM_IRQ-1:0] mask_o,
    output logic [NUM_IRQ-1:0] pending_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic                 irq_q, irq_d;
    logic [4:0]           irq_id_q, irq_id_d;
    logic [NUM_IRQ-1:0]   pending_q, pending_d;
    logic [NUM_IRQ-1:0]   mask_q, mask_d;
    logic [NUM_IRQ-1:0]   src_event_s;
    logic [NUM_IRQ-1:0]   active_s;
    logic [31:0]          active_ext_s;
    logic [31:0]          ack_onehot_s;
    logic [NUM_IRQ-1:0]   ack_clr_s;
    logic                 ack_take_s;

    // Lowest set index of v; returns 0 when v is empty (caller guards with |v).
    function automatic logic [4:0] lowest_idx(input logic [NUM_IRQ-1:0] v);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 5'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

`ifdef IRQ_EDGE_DETECT_EN
    logic [NUM_IRQ-1:0] src_prev_q;

    // Previous source levels for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_prev_q <= {NUM_IRQ{1'b0}};
        end else begin
            src_prev_q <= irq_src_i;
        end
    end

    assign src_event_s = irq_src_i & ~src_prev_q;
`else
    assign src_event_s = irq_src_i;
`endif

    // Next-state logic for the request FSM, pending and mask registers.
    always_comb begin
        state_d      = state_q;
        irq_id_d     = irq_id_q;
        ack_take_s   = 1'b0;
        active_s     = pending_q & mask_q;
        active_ext_s = 32'(active_s);
        // Ids beyond NUM_IRQ shift out of the vector and so clear nothing.
        ack_onehot_s = 32'd1 << irq_ack_id_i;

        case (state_q)
            S_IDLE: begin
                if (|active_s) begin
                    state_d  = S_REQ;
                    irq_id_d = lowest_idx(active_s);
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_REQ: begin
                if (irq_ack_i) begin
                    state_d    = S_DONE;
                    ack_take_s = 1'b1;
                end else if (!active_ext_s[irq_id_q]) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (ack_take_s) begin
            ack_clr_s = ack_onehot_s[NUM_IRQ-1:0];
        end else begin
            ack_clr_s = {NUM_IRQ{1'b0}};
        end

        // Set terms are OR-ed in last so a same-cycle event beats any clear.
        pending_d = (pending_q & ~(pend_clr_i | ack_clr_s)) | src_event_s | pend_set_i;

        if (mask_we_i) begin
            mask_d = mask_wdata_i;
        end else begin
            mask_d = mask_q;
        end

        irq_d = (state_d == S_REQ);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            irq_q     <= 1'b0;
            irq_id_q  <= 5'd0;
            pending_q <= {NUM_IRQ{1'b0}};
            mask_q    <= {NUM_IRQ{1'b0}};
        end else begin
            state_q   <= state_d;
            irq_q     <= irq_d;
            irq_id_q  <= irq_id_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
        end
    end

    assign irq_o     = irq_q;
    assign irq_id_o  = irq_id_q;
    assign mask_o    = mask_q;
    assign pending_o = pending_q;

endmodule

// File: tb/tb_zeroriscy_irq_arbiter.sv
// Directed bench for zeroriscy_irq_arbiter: a cycle model checked against the DUT every cycle plus hand-computed literals.
module tb_zeroriscy_irq_arbiter;

    localparam int N = 32;
    localparam logic [1:0] M_IDLE = 2'd0;
    localparam logic [1:0] M_REQ  = 2'd1;
    localparam logic [1:0] M_DONE = 2'd2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] irq_src_i = '0;
    logic         mask_we_i = 1'b0;
    logic [N-1:0] mask_wdata_i = '0;
    logic [N-1:0] pend_set_i = '0;
    logic [N-1:0] pend_clr_i = '0;
    logic         irq_o;
    logic [4:0]   irq_id_o;
    logic         irq_ack_i = 1'b0;
    logic [4:0]   irq_ack_id_i = 5'd0;
    logic [N-1:0] mask_o;
    logic [N-1:0] pending_o;

    int n_vec = 0;
    int n_err = 0;

    zeroriscy_irq_arbiter #(.NUM_IRQ(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq_src_i    (irq_src_i),
        .mask_we_i    (mask_we_i),
        .mask_wdata_i (mask_wdata_i),
        .pend_set_i   (pend_set_i),
        .pend_clr_i   (pend_clr_i),
        .irq_o        (irq_o),
        .irq_id_o     (irq_id_o),
        .irq_ack_i    (irq_ack_i),
        .irq_ack_id_i (irq_ack_id_i),
        .mask_o       (mask_o),
        .pending_o    (pending_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] pend;
        logic [N-1:0] mask;
        logic [N-1:0] prev;
        logic [1:0]   st;
        logic [4:0]   id;
    } mstate_t;

    mstate_t m;

    // Behavioural rules: per-bit pending update, then the request handshake.
    function automatic mstate_t model_next(input mstate_t s);
        mstate_t      n;
        logic [N-1:0] act;
        bit           acked;
        bit           ev;
        n     = s;
        act   = s.pend & s.mask;
        acked = (s.st == M_REQ) && irq_ack_i;
        for (int b = 0; b < N; b++) begin
`ifdef IRQ_EDGE_DETECT_EN
            ev = irq_src_i[b] && !s.prev[b];
`else
            ev = irq_src_i[b];
`endif
            ev = ev || pend_set_i[b];
            if (ev) n.pend[b] = 1'b1;
            else if (pend_clr_i[b] || (acked && int'(irq_ack_id_i) == b)) n.pend[b] = 1'b0;
        end
        n.prev = irq_src_i;
        n.mask = mask_we_i ? mask_wdata_i : s.mask;
        case (s.st)
            M_IDLE: begin
                if (act != '0) begin
                    n.st = M_REQ;
                    for (int b = N - 1; b >= 0; b--) if (act[b]) n.id = 5'(b);
                end
            end
            M_REQ: begin
                if (irq_ack_i) n.st = M_DONE;
                else if (!act[s.id]) n.st = M_IDLE;
            end
            default: n.st = M_IDLE;
        endcase
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= model_next(m);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: compare DUT against the model at the falling edge, then step past it.
    task automatic clk1();
        @(negedge clk);
        chk("cyc_irq_o",     32'(irq_o),     32'(m.st == M_REQ));
        chk("cyc_irq_id_o",  32'(irq_id_o),  32'(m.id));
        chk("cyc_pending_o", 32'(pending_o), 32'(m.pend));
        chk("cyc_mask_o",    32'(mask_o),    32'(m.mask));
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    int reqs;
    int acks;
    logic prev_irq;

    initial begin
        clk1(); clk1();
        chk("rst_irq_o", 32'(irq_o), 32'd0);
        chk("rst_id", 32'(irq_id_o), 32'd0);
        chk("rst_pending", pending_o, 32'h0);
        chk("rst_mask", mask_o, 32'h0);
        rst_n = 1'b1;
        clk1();

        // Masked source pulse latches pending but raises no request
        irq_src_i = 32'h8; clk1(); irq_src_i = '0;
        chk("t30_pending", pending_o, 32'h8);
        chk("t30_irq_masked", 32'(irq_o), 32'd0);
        clk1(); clk1();
        chk("t30_irq_still0", 32'(irq_o), 32'd0);
        mask_we_i = 1'b1; mask_wdata_i = 32'h8; clk1(); mask_we_i = 1'b0;
        chk("t30_mask_vis", mask_o, 32'h8);
        chk("t30_irq_not_yet", 32'(irq_o), 32'd0);
        clk1();
        chk("t30_irq", 32'(irq_o), 32'd1);
        chk("t30_id", 32'(irq_id_o), 32'd3);
        irq_ack_i = 1'b1; irq_ack_id_i = 5'd3; clk1(); irq_ack_i = 1'b0;
        chk("t30_ack_clr", pending_o, 32'h0);
        clk1();

        // Two pending, lowest wins, second follows after DONE
        mask_we_i = 1'b1; mask_wdata_i = 32'hFFFF_FFFF; clk1(); mask_we_i = 1'b0;
        pend_set_i = 32'h24; clk1(); pend_set_i = '0;
        clk1();
        chk("t31_irq", 32'(irq_o), 32'd1);
        chk("t31_id2", 32'(irq_id_o), 32'd2);
        irq_ack_i = 1'b1; irq_ack_id_i = 5'd2; clk1(); irq_ack_i = 1'b0;
        chk("t31_done_irq", 32'(irq_o), 32'd0);
        chk("t31_done_pend", pending_o, 32'h20);
        chk("t31_done_id_hold", 32'(irq_id_o), 32'd2);
        clk1();
        chk("t31_idle_irq", 32'(irq_o), 32'd0);
        clk1();
        chk("t31_irq5", 32'(irq_o), 32'd1);
        chk("t31_id5", 32'(irq_id_o), 32'd5);
        irq_ack_i = 1'b1; irq_ack_id_i = 5'd5; clk1(); irq_ack_i = 1'b0;
        clk1();

        // Software clear withdraws the request
        pend_set_i = 32'h10; clk1(); pend_set_i = '0;
        clk1();
        chk("t32_id4", 32'(irq_id_o), 32'd4);
        pend_clr_i = 32'h10; clk1(); pend_clr_i = '0;
        chk("t32_pend_clr", pending_o, 32'h0);
        clk1();
        chk("t32_withdraw", 32'(irq_o), 32'd0);
        clk1();

        // Ack coincident with a new event on the same bit
        pend_set_i = 32'h80; clk1(); pend_set_i = '0;
        clk1();
        chk("t33_id7", 32'(irq_id_o), 32'd7);
        irq_ack_i = 1'b1; irq_ack_id_i = 5'd7; irq_src_i = 32'h80; clk1();
        irq_ack_i = 1'b0; irq_src_i = '0;
        chk("t33_pend_kept", pending_o, 32'h80);
        clk1(); clk1();
        chk("t33_rereq", 32'(irq_o), 32'd1);
        chk("t33_rereq_id", 32'(irq_id_o), 32'd7);
        irq_ack_i = 1'b1; clk1(); irq_ack_i = 1'b0;
        clk1();

        // Line held high, acked once: count requests
        irq_src_i = 32'h2; acks = 0; reqs = 0; prev_irq = irq_o;
        for (int i = 0; i < 10; i++) begin
            if (irq_o && acks == 0) begin
                irq_ack_i = 1'b1; irq_ack_id_i = 5'd1; acks++;
            end else begin
                irq_ack_i = 1'b0;
            end
            clk1();
            if (irq_o && !prev_irq) reqs++;
            prev_irq = irq_o;
        end
        irq_ack_i = 1'b0; irq_src_i = '0;
`ifdef IRQ_EDGE_DETECT_EN
        chk("t34_req_count", 32'(reqs), 32'd1);
`else
        chk("t34_req_count", 32'(reqs), 32'd2);
`endif
        pend_clr_i = 32'hFFFF_FFFF; clk1(); clk1(); clk1(); pend_clr_i = '0;
        clk1();

        // Asynchronous reset during REQ
        pend_set_i = 32'h1; clk1(); pend_set_i = '0;
        clk1();
        chk("t35_in_req", 32'(irq_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t35_async_irq", 32'(irq_o), 32'd0);
        chk("t35_async_pend", pending_o, 32'h0);
        chk("t35_async_mask", mask_o, 32'h0);
        chk("t35_async_id", 32'(irq_id_o), 32'd0);
        clk1(); clk1();
        rst_n = 1'b1;
        clk1();

        // Ack outside REQ is ignored; no request until mask written
        pend_set_i = 32'h1; clk1(); pend_set_i = '0;
        irq_ack_i = 1'b1; irq_ack_id_i = 5'd0; clk1(); irq_ack_i = 1'b0;
        chk("t23_ack_ignored", pending_o, 32'h1);
        clk1();
        chk("t35_no_req", 32'(irq_o), 32'd0);
        mask_we_i = 1'b1; mask_wdata_i = 32'h1; clk1(); mask_we_i = 1'b0;
        clk1();
        chk("t35_req_after_mask", 32'(irq_o), 32'd1);
        chk("t35_id0", 32'(irq_id_o), 32'd0);
        clk1();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/zeroriscy_irq_arbiter.md
ZERORISCY_IRQ_ARBITER -- requirements
Module: zeroriscy_irq_arbiter

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 32, number of interrupt source lines (legal 1..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port irq_src_i  input  NUM_IRQ  peripheral interrupt lines, bit n = source n.
REQ-005 SHALL have port mask_we_i  input  1  write strobe for enable mask.
REQ-006 SHALL have port mask_wdata_i  input  NUM_IRQ  new enable mask value.
REQ-007 SHALL have port pend_set_i  input  NUM_IRQ  software pending set, one-hot or multi-bit.
REQ-008 SHALL have port pend_clr_i  input  NUM_IRQ  software pending clear.
REQ-009 SHALL have port irq_o  output  1  interrupt request to core (core irq_i).
REQ-010 SHALL have port irq_id_o  output  5  request id to core (core irq_id_i).
REQ-011 SHALL have port irq_ack_i  input  1  core acknowledge, single-cycle pulse.
REQ-012 SHALL have port irq_ack_id_i  input  5  id the core took.
REQ-013 SHALL have ports mask_o, pending_o  output  NUM_IRQ  current enable mask and pending register.

Function
REQ-014 SHALL hold pending[n] set by a source event on irq_src_i[n] or pend_set_i[n]; cleared only by pend_clr_i[n] or by ack with irq_ack_id_i == n.
REQ-015 SHALL give set priority over clear in the same cycle for the same bit (event never lost), including ack-clear.
REQ-016 SHALL load mask from mask_wdata_i on mask_we_i; mask change visible to arbitration next cycle.
REQ-017 SHALL arbitrate over pending & mask, lowest index wins.
REQ-018 SHALL implement states IDLE, REQ, DONE; irq_o = 1 only in REQ.
REQ-019 IDLE: if any pending & mask bit set, latch winner id into irq_id_o, go REQ next cycle (irq_o rises 1 cycle after pending bit is visible).
REQ-020 REQ: irq_id_o frozen; on irq_ack_i go DONE and clear pending[irq_ack_id_i]; ack with id other than latched still clears that bit and goes DONE.
REQ-021 REQ without ack: if latched source is no longer pending & mask, go IDLE (withdraw; irq_o low next cycle); ack takes priority over withdraw in the same cycle.
REQ-022 DONE: unconditional return to IDLE after one cycle, matching core one-cycle ack turnaround; no new request issued in DONE.
REQ-023 SHALL ignore irq_ack_i outside REQ (no pending clear, no state change).
REQ-024 SHALL ignore ack ids >= NUM_IRQ for pending clear; state transition still occurs.
REQ-025 irq_id_o SHALL hold last latched value in IDLE and DONE.

Reset
REQ-026 On rst_n low: state IDLE, irq_o 0, irq_id_o 0, pending 0, mask 0 (all disabled), edge history 0; effective immediately, including mid-REQ.
REQ-027 After reset release, no request until software writes mask.

Configuration
REQ-028 Macro IRQ_EDGE_DETECT_EN defined: source event = rising edge of irq_src_i[n] (registered previous value; high level held does not re-set after clear).
REQ-029 Macro IRQ_EDGE_DETECT_EN undefined: source event = irq_src_i[n] high each cycle (level; pending re-sets while line stays high); no edge registers built.

Verification
REQ-030 Reset, mask=0x0, irq_src_i[3] pulses -> pending_o=0x8, irq_o stays 0; then mask=0x8 -> irq_o=1, irq_id_o=3 one cycle after mask visible.
REQ-031 pending 0x24, mask all-ones -> irq_id_o=2; ack id 2 -> DONE one cycle, IDLE, then irq_id_o=5 request.
REQ-032 In REQ id 4, pend_clr_i=0x10 -> irq_o low next cycle, state IDLE, no spurious ack clear.
REQ-033 Ack id 7 cycle coincident with new source event on bit 7 -> pending_o[7] stays 1, new request id 7 after DONE.
REQ-034 With IRQ_EDGE_DETECT_EN: line 1 held high 10 cycles, acked once -> exactly one request; without macro -> request re-issued after DONE.
REQ-035 rst_n low during REQ -> irq_o=0, pending_o=0, mask_o=0 asynchronously, no request after release until mask written.
